// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen -- fractional (phase-accumulator) baud-rate generator.
//
// Each enabled cycle the accumulator advances by BAUD*OVERSAMPLE. When it
// reaches CLK_FREQ, CLK_FREQ is subtracted and an oversample tick is issued.
// Tick intervals are therefore floor/ceil of CLK_FREQ/INC cycles, and the
// long-term rate is exact.
//
// Ports
//   pll_clk  in   clock; all logic on the rising edge
//   rst      in   synchronous active-high reset; overrides en and baud_sel
//   en       in   generator enable; while low, acc/os_cnt/ticks/clk_out read 0
//   baud_sel in   rate code 0..9 = 4800..921600 baud; 10..15 are invalid
//   os_tick  out  one-cycle strobe, OVERSAMPLE per bit period
//   bit_tick out  one-cycle strobe on the os_tick that completes a bit period
//   clk_out  out  square wave that toggles on every os_tick
//   sel_err  out  registered flag, high while baud_sel holds an invalid code
// -----------------------------------------------------------------------------
module baud_gen #(
    parameter int unsigned CLK_FREQ   = 120_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 28
) (
    input  logic       pll_clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] baud_sel,
    output logic       os_tick,
    output logic       bit_tick,
    output logic       clk_out,
    output logic       sel_err
);

    localparam int unsigned     CNT_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [ACC_W:0]  CLK_FREQ_W = (ACC_W + 1)'(CLK_FREQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      SEL_RESET  = 4'd1;
    localparam logic [3:0]      SEL_MAX    = 4'd9;

    // Baud rates by code. Codes 10-15 hold 0; they can never be latched into
    // cur_sel, so those entries are unreachable.
    localparam int unsigned BAUD_TBL [16] = '{
        4800, 9600, 14400, 19200, 38400, 57600, 115200, 230400,
        460800, 921600, 0, 0, 0, 0, 0, 0
    };

    // Parameter sanity: the increment must stay at most half the clock rate,
    // and the accumulator must hold CLK_FREQ plus headroom.
    if (CLK_FREQ < 2 * 921600 * OVERSAMPLE) begin : g_clk_too_slow
        $error("baud_gen: CLK_FREQ must be at least 2*921600*OVERSAMPLE");
    end
    if (ACC_W < $clog2(CLK_FREQ) + 1) begin : g_acc_too_narrow
        $error("baud_gen: ACC_W must be at least clog2(CLK_FREQ)+1");
    end

    // Per-code phase increment (BAUD * OVERSAMPLE), one extra bit of headroom.
    logic [ACC_W:0] inc_tbl [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_inc
        assign inc_tbl[gi] = (ACC_W + 1)'(BAUD_TBL[gi] * OVERSAMPLE);
    end

    logic [3:0]       cur_sel_q, cur_sel_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             clk_out_q, clk_out_d;
    logic             sel_err_q, sel_err_d;

    logic             sel_valid;
    logic             reload;
    logic [ACC_W:0]   inc;
    logic [ACC_W:0]   acc_next;

    assign sel_valid = (baud_sel <= SEL_MAX);
    // A valid code differing from the latched one restarts the generator.
    assign reload    = sel_valid && (baud_sel != cur_sel_q);
    assign inc       = inc_tbl[cur_sel_q];
    assign acc_next  = {1'b0, acc_q} + inc;

    always_comb begin
        cur_sel_d  = cur_sel_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        clk_out_d  = clk_out_q;
        // Invalid codes only raise the flag; the running rate is untouched.
        sel_err_d  = !sel_valid;

        if (reload) begin
            // Reload wins over a simultaneous crossing: the tick is dropped.
            cur_sel_d = baud_sel;
            acc_d     = '0;
            os_cnt_d  = '0;
            clk_out_d = 1'b0;
        end else if (!en) begin
            acc_d     = '0;
            os_cnt_d  = '0;
            clk_out_d = 1'b0;
        end else if (acc_next >= CLK_FREQ_W) begin
            // Keep the remainder so the long-term rate carries no error.
            acc_d     = ACC_W'(acc_next - CLK_FREQ_W);
            os_tick_d = 1'b1;
            clk_out_d = !clk_out_q;
            if (os_cnt_q == CNT_LAST) begin
                os_cnt_d   = '0;
                bit_tick_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + CNT_W'(1);
            end
        end else begin
            acc_d = ACC_W'(acc_next);
        end
    end

    always_ff @(posedge pll_clk) begin
        if (rst) begin
            cur_sel_q  <= SEL_RESET;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            clk_out_q  <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            cur_sel_q  <= cur_sel_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            clk_out_q  <= clk_out_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign clk_out  = clk_out_q;
    assign sel_err  = sel_err_q;

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 120_000_000: pll_clk frequency in Hz.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16: os_tick pulses per bit period.
REQ-003 The block SHALL have parameter ACC_W, default 28: phase-accumulator width in bits; ACC_W SHALL be at least clog2(CLK_FREQ)+1.
REQ-004 The block SHALL have port pll_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: generator enable.
REQ-007 The block SHALL have port baud_sel, input, 4 bits: runtime baud-rate select code.
REQ-008 The block SHALL have port os_tick, output, 1 bit: one-cycle oversample strobe at BAUD*OVERSAMPLE average rate.
REQ-009 The block SHALL have port bit_tick, output, 1 bit: one-cycle strobe once per bit period.
REQ-010 The block SHALL have port clk_out, output, 1 bit: square wave toggling on each os_tick.
REQ-011 The block SHALL have port sel_err, output, 1 bit: registered flag, high while baud_sel is an unsupported code.

Function
REQ-012 baud_sel codes SHALL map as 0:4800, 1:9600, 2:14400, 3:19200, 4:38400, 5:57600, 6:115200, 7:230400, 8:460800, 9:921600; codes 10-15 are invalid.
REQ-013 The active increment SHALL be INC = BAUD*OVERSAMPLE of the current latched selection (cur_sel).
REQ-014 While en=1, on each edge acc_next = acc + INC; if acc_next >= CLK_FREQ then acc <= acc_next - CLK_FREQ and os_tick <= 1, else acc <= acc_next and os_tick <= 0.
REQ-015 The long-term os_tick rate SHALL be exact (no cumulative error); individual intervals SHALL be floor or ceil of CLK_FREQ/INC cycles.
REQ-016 A counter os_cnt SHALL count os_ticks 0..OVERSAMPLE-1 and wrap to 0.
REQ-017 bit_tick SHALL assert in the same cycle as the os_tick on which os_cnt wraps from OVERSAMPLE-1 to 0.
REQ-018 clk_out SHALL toggle in the cycle each os_tick asserts.
REQ-019 While en=0, acc, os_cnt, os_tick, bit_tick and clk_out SHALL be held at 0.
REQ-020 When en rises, accumulation SHALL start from acc=0.
REQ-021 baud_sel SHALL be compared with cur_sel every cycle.
REQ-022 If baud_sel is valid and differs from cur_sel, then on the next edge: cur_sel <= baud_sel; acc, os_cnt and clk_out clear to 0; no os_tick or bit_tick is issued in that cycle.
REQ-023 A reload per REQ-022 SHALL take priority over a simultaneous accumulator crossing; the tick is suppressed.
REQ-024 If baud_sel is invalid: sel_err <= 1 on the next edge; cur_sel, acc and os_cnt continue unaffected; sel_err <= 0 on the first edge after baud_sel is valid again.
REQ-025 Elaboration SHALL fail (generate-time check) if CLK_FREQ < 2*921600*OVERSAMPLE.

Reset
REQ-026 When rst=1 at an edge: acc=0, os_cnt=0, os_tick=0, bit_tick=0, clk_out=0, sel_err=0, cur_sel=1 (9600).
REQ-027 rst SHALL dominate en and baud_sel.
REQ-028 After a reset asserted mid-operation, no tick SHALL be issued until a full accumulation period has elapsed.
REQ-029 No state SHALL depend on power-up initial values.

Verification
REQ-030 Defaults, rst 1 cycle, then en=1, baud_sel=1 -> first os_tick 782 edges after the first en=1 edge; 4 consecutive os_ticks span exactly 3125 cycles; bit_tick every 12500 cycles.
REQ-031 baud_sel=6 (115200) -> os_tick intervals of only 65 or 66 cycles; 16 bit periods span exactly 16*16*120e6/1843200 = 16666.67 +/-1 cycles.
REQ-032 Change baud_sel 1->9 mid-bit, including in a crossing cycle -> no tick in the reload cycle; acc and os_cnt = 0; subsequent intervals 8 or 9 cycles.
REQ-033 baud_sel=12 while running at 9600 -> sel_err=1 next cycle; tick cadence unchanged; baud_sel=3 -> sel_err=0, 19200 cadence (intervals 390/391).
REQ-034 en dropped for 100 cycles mid-bit, then rerun -> outputs 0 throughout; first os_tick 782 cycles after re-enable.
REQ-035 rst pulsed while running at 921600 -> all outputs 0 next cycle; cur_sel = 9600 regardless of baud_sel until it is re-sampled as a differing valid code.
